// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte-stream requesters.
// Ownership is held for a whole packet; idle gap and stall timeout are counted in s_ticks.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int D_BITS      = 8,
    parameter int GAP_TICKS   = 16,
    parameter int STALL_TICKS = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      s_tick,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*D_BITS-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          grant,
    output logic                      tx_start,
    output logic [D_BITS-1:0]         tx_din,
    input  logic                      tx_done_tick,
    output logic                      busy,
    output logic                      abort_tick
);

    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W   = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int STALL_W = $clog2(STALL_TICKS + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    logic [1:0]         state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic               last_r;
    logic [STALL_W-1:0] stall_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic               xfer;
    logic [STALL_W-1:0] stall_inc;
    logic [GAP_W-1:0]   gap_inc;

    // Rotating search from ptr; walking offsets downward lets the smallest offset win.
    // NOTE: every variable gets a default at the top of always_comb so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        cand     = '0;
        pick_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(ptr) + k) % N_REQ);
            if (req_valid[cand]) begin
                pick_idx = cand;
            end
        end
        next_ptr = PTR_W'((int'(pick_idx) + 1) % N_REQ);
    end

    always_comb begin
        req_ready = (state == LOAD) ? grant : '0;
        xfer      = (state == LOAD) && (|(req_valid & grant));
        busy      = (state != IDLE);
        stall_inc = (stall_cnt == STALL_W'(STALL_TICKS)) ? stall_cnt : stall_cnt + 1'b1;
        gap_inc   = (gap_cnt == GAP_W'(GAP_TICKS)) ? gap_cnt : gap_cnt + 1'b1;
    end

    // NOTE: all state in this block uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            grant      <= '0;
            last_r     <= 1'b0;
            tx_din     <= '0;
            tx_start   <= 1'b0;
            abort_tick <= 1'b0;
            stall_cnt  <= '0;
            gap_cnt    <= '0;
        end else begin
            tx_start   <= 1'b0;
            abort_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        owner     <= pick_idx;
                        ptr       <= next_ptr;
                        stall_cnt <= '0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    // A transfer takes priority over a coincident final stall tick.
                    if (xfer) begin
                        tx_din   <= req_data[owner*D_BITS +: D_BITS];
                        last_r   <= req_last[owner];
                        tx_start <= 1'b1;
                        state    <= SEND;
                    end else if (s_tick) begin
                        stall_cnt <= stall_inc;
                        if (stall_inc == STALL_W'(STALL_TICKS)) begin
                            abort_tick <= 1'b1;
                            grant      <= '0;
                            gap_cnt    <= '0;
                            state      <= GAP;
                        end
                    end
                end
                SEND: begin
                    if (tx_done_tick) begin
                        if (last_r) begin
                            grant   <= '0;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            stall_cnt <= '0;
                            state     <= LOAD;
                        end
                    end
                end
                GAP: begin
                    if (GAP_TICKS == 0) begin
                        state <= IDLE;
                    end else if (s_tick) begin
                        gap_cnt <= gap_inc;
                        if (gap_inc == GAP_W'(GAP_TICKS)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues, a 160-clk transmitter model,
// and a second instance with GAP_TICKS = 0.
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int D       = 8;
    localparam int TX_CLKS = 160;

    typedef struct packed {
        logic [D-1:0] data;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [7:0]   idx;
        logic [D-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    logic           s_tick;
    logic [N-1:0]   req_valid;
    logic [N*D-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [D-1:0]   tx_din;
    logic           tx_done_tick;
    logic           busy;
    logic           abort_tick;

    logic [N-1:0]   b_valid;
    logic [N*D-1:0] b_data;
    logic [N-1:0]   b_last;
    logic [N-1:0]   b_ready;
    logic [N-1:0]   b_grant;
    logic           b_start;
    logic [D-1:0]   b_din;
    logic           b_done;
    logic           b_busy;
    logic           b_abort;

    int checks = 0;
    int errors = 0;
    int tick_raised = 0;
    int done_raised = 0;
    int starts_seen = 0;
    int aborts_seen = 0;
    int tx_cnt = 0;
    int tick_div = 0;
    bit took [N];

    beat_t rq [N][$];
    exp_t  sb_q[$];
    beat_t drv_b;
    exp_t  mon_e;
    logic [N-1:0] mon_g;

    uart_tx_arbiter #(.N_REQ(N), .D_BITS(D), .GAP_TICKS(16), .STALL_TICKS(4)) dut (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant), .tx_start(tx_start), .tx_din(tx_din),
        .tx_done_tick(tx_done_tick), .busy(busy), .abort_tick(abort_tick)
    );

    uart_tx_arbiter #(.N_REQ(N), .D_BITS(D), .GAP_TICKS(0), .STALL_TICKS(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick),
        .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
        .req_ready(b_ready), .grant(b_grant), .tx_start(b_start), .tx_din(b_din),
        .tx_done_tick(b_done), .busy(b_busy), .abort_tick(b_abort)
    );

    // Models drive on the falling edge; tasks sample 2 time units after the rising edge.
    always @(negedge clk) begin : tick_model
        s_tick = (tick_div == 3);
        if (s_tick) tick_raised++;
        tick_div = (tick_div + 1) % 4;
    end

    always @(negedge clk) begin : tx_model
        tx_done_tick = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_done_tick = 1'b1;
                done_raised++;
            end
        end
        if (tx_start) tx_cnt = TX_CLKS - 1;
    end

    always @(negedge clk) begin : req_driver
        for (int i = 0; i < N; i++) begin
            if (took[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
                drv_b = rq[i][0];
                req_valid[i]       = 1'b1;
                req_data[i*D +: D] = drv_b.data;
                req_last[i]        = drv_b.last;
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
            took[i] = reset_n && req_valid[i] && req_ready[i];
        end
    end

    always @(negedge clk) begin : monitor
        if (reset_n) begin
            checks++;
            if (!$onehot0(grant)) begin
                errors++;
                $display("FAIL grant_onehot: grant=%b required at most one bit set", grant);
            end
            if (abort_tick) aborts_seen++;
            if (tx_start) begin
                starts_seen++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tx_start: tx_din=%h grant=%b required no tx_start", tx_din, grant);
                end else begin
                    mon_e = sb_q.pop_front();
                    mon_g = 4'b0001 << mon_e.idx;
                    if (tx_din !== mon_e.data || grant !== mon_g) begin
                        errors++;
                        $display("FAIL tx_byte: tx_din=%h grant=%b required tx_din=%h grant=%b",
                                 tx_din, grant, mon_e.data, mon_g);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int idx, input logic [D-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        rq[idx].push_back(b);
    endtask

    task automatic expect_tx(input int idx, input logic [D-1:0] d);
        exp_t e;
        e.idx  = 8'(idx);
        e.data = d;
        sb_q.push_back(e);
    endtask

    function automatic bit pending();
        bit p = (sb_q.size() != 0);
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        sb_q.delete();
        b_valid = '0; b_data = '0; b_last = '0; b_done = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic wait_grant();
        int n = 0;
        while (grant === '0 && n < 400) begin step(); n++; end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || pending()) && n < 6000) begin step(); n++; end
        checks++;
        if (busy || pending()) begin
            errors++;
            $display("FAIL %s_drain: busy=%b scoreboard=%0d required idle and empty", name, busy, sb_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) step();
        checks++;
        if ({grant, req_ready, tx_start, tx_din, busy, abort_tick} !== '0) begin
            errors++;
            $display("FAIL reset_a: grant=%b ready=%b start=%b din=%h busy=%b abort=%b required all 0",
                     grant, req_ready, tx_start, tx_din, busy, abort_tick);
        end
        checks++;
        if ({b_grant, b_ready, b_start, b_din, b_busy, b_abort} !== '0) begin
            errors++;
            $display("FAIL reset_b: grant=%b ready=%b start=%b din=%h busy=%b abort=%b required all 0",
                     b_grant, b_ready, b_start, b_din, b_busy, b_abort);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_packet();
        int d0, s0, t0, n;
        bit bad;
        logic [N-1:0] bad_g;
        apply_reset();
        d0 = done_raised;
        s0 = starts_seen;
        push(0, 8'hA5, 1'b0); push(0, 8'h3C, 1'b0); push(0, 8'h81, 1'b1);
        expect_tx(0, 8'hA5); expect_tx(0, 8'h3C); expect_tx(0, 8'h81);
        wait_grant();
        bad = 1'b0; bad_g = '0; n = 0;
        while (done_raised - d0 < 3 && n < 2000) begin
            if (grant !== 4'b0001 && !bad) begin bad = 1'b1; bad_g = grant; end
            step(); n++;
        end
        checks++;
        if (bad || n >= 2000) begin
            errors++;
            $display("FAIL single_grant_hold: grant=%b required 0001 until third done", bad_g);
        end
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant_release: grant=%b busy=%b required 0000 and 1", grant, busy);
        end
        t0 = tick_raised; n = 0;
        while (busy && n < 500) begin step(); n++; end
        checks++;
        if (busy || tick_raised - t0 != 16) begin
            errors++;
            $display("FAIL single_gap_len: ticks=%0d busy=%b required 16 and 0", tick_raised - t0, busy);
        end
        wait_idle("single");
        checks++;
        if (starts_seen - s0 != 3) begin
            errors++;
            $display("FAIL single_start_count: got %0d required 3", starts_seen - s0);
        end
    endtask

    task automatic test_round_robin();
        int s0;
        apply_reset();
        s0 = starts_seen;
        push(0, 8'h11, 1'b1); push(0, 8'h33, 1'b1);
        push(2, 8'h22, 1'b1); push(2, 8'h44, 1'b1);
        expect_tx(0, 8'h11); expect_tx(2, 8'h22); expect_tx(0, 8'h33); expect_tx(2, 8'h44);
        wait_idle("round_robin");
        checks++;
        if (starts_seen - s0 != 4) begin
            errors++;
            $display("FAIL rr_start_count: got %0d required 4", starts_seen - s0);
        end
    endtask

    task automatic test_packet_lock();
        int d0, n;
        bit bad;
        logic [N-1:0] bad_g, bad_r;
        apply_reset();
        d0 = done_raised;
        push(1, 8'h10, 1'b0); push(1, 8'h20, 1'b0); push(1, 8'h30, 1'b0); push(1, 8'h40, 1'b1);
        push(3, 8'h3F, 1'b1);
        expect_tx(1, 8'h10); expect_tx(1, 8'h20); expect_tx(1, 8'h30); expect_tx(1, 8'h40);
        expect_tx(3, 8'h3F);
        wait_grant();
        bad = 1'b0; bad_g = '0; bad_r = '0; n = 0;
        while (done_raised - d0 < 4 && n < 2500) begin
            if ((grant !== 4'b0010 || req_ready[3] !== 1'b0) && !bad) begin
                bad = 1'b1; bad_g = grant; bad_r = req_ready;
            end
            step(); n++;
        end
        checks++;
        if (bad || n >= 2500) begin
            errors++;
            $display("FAIL lock_hold: grant=%b ready=%b required grant 0010 ready[3] 0", bad_g, bad_r);
        end
        wait_grant();
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL lock_next_owner: grant=%b required 1000", grant);
        end
        wait_idle("lock");
    endtask

    task automatic test_stall();
        int d0, a0, t0, n;
        apply_reset();
        d0 = done_raised;
        a0 = aborts_seen;
        push(2, 8'hC3, 1'b0);
        push(3, 8'hD4, 1'b1);
        expect_tx(2, 8'hC3); expect_tx(3, 8'hD4);
        wait_grant();
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL stall_first_owner: grant=%b required 0100", grant);
        end
        n = 0;
        while (done_raised == d0 && n < 400) begin step(); n++; end
        t0 = tick_raised; n = 0;
        while (abort_tick !== 1'b1 && n < 200) begin step(); n++; end
        checks++;
        if (abort_tick !== 1'b1 || grant !== 4'b0000 || tick_raised - t0 != 4) begin
            errors++;
            $display("FAIL stall_abort: abort=%b grant=%b ticks=%0d required 1 0000 4",
                     abort_tick, grant, tick_raised - t0);
        end
        wait_idle("stall");
        checks++;
        if (aborts_seen - a0 != 1) begin
            errors++;
            $display("FAIL stall_abort_count: got %0d required 1", aborts_seen - a0);
        end
    endtask

    task automatic test_reset_mid_send();
        int s0, d0, n;
        apply_reset();
        s0 = starts_seen;
        push(2, 8'h5A, 1'b0); push(2, 8'h6B, 1'b1);
        expect_tx(2, 8'h5A);
        n = 0;
        while (starts_seen == s0 && n < 50) begin step(); n++; end
        d0 = done_raised;
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        sb_q.delete();
        #1;
        checks++;
        if ({grant, req_ready, tx_start, tx_din, busy, abort_tick} !== '0) begin
            errors++;
            $display("FAIL midsend_async_reset: grant=%b ready=%b start=%b din=%h busy=%b abort=%b required all 0",
                     grant, req_ready, tx_start, tx_din, busy, abort_tick);
        end
        repeat (2) step();
        reset_n = 1'b1;
        s0 = starts_seen; n = 0;
        while (done_raised == d0 && n < 300) begin step(); n++; end
        repeat (4) step();
        checks++;
        if (done_raised == d0 || starts_seen != s0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_done: done_seen=%0d starts=%0d busy=%b required 1 0 0",
                     done_raised - d0, starts_seen - s0, busy);
        end
        push(1, 8'h71, 1'b1); push(3, 8'h73, 1'b1);
        expect_tx(1, 8'h71); expect_tx(3, 8'h73);
        wait_grant();
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL reset_ptr_order: grant=%b required 0010", grant);
        end
        wait_idle("midsend");
    endtask

    task automatic test_gap_zero();
        apply_reset();
        b_data  = {8'h00, 8'h00, 8'h77, 8'h66};
        b_last  = 4'b0011;
        b_valid = 4'b0011;
        step();
        checks++;
        if (b_grant !== 4'b0001 || b_ready !== 4'b0001) begin
            errors++;
            $display("FAIL gap0_first_grant: grant=%b ready=%b required 0001 0001", b_grant, b_ready);
        end
        step();
        checks++;
        if (b_start !== 1'b1 || b_din !== 8'h66) begin
            errors++;
            $display("FAIL gap0_start: start=%b din=%h required 1 66", b_start, b_din);
        end
        b_valid = 4'b0010;
        repeat (2) step();
        b_done = 1'b1;
        step();
        b_done = 1'b0;
        checks++;
        if (b_busy !== 1'b1 || b_grant !== 4'b0000) begin
            errors++;
            $display("FAIL gap0_enter_gap: busy=%b grant=%b required 1 0000", b_busy, b_grant);
        end
        step();
        checks++;
        if (b_busy !== 1'b0) begin
            errors++;
            $display("FAIL gap0_idle: busy=%b required 0 one clk after done", b_busy);
        end
        step();
        checks++;
        if (b_grant !== 4'b0010) begin
            errors++;
            $display("FAIL gap0_next_grant: grant=%b required 0010", b_grant);
        end
        b_valid = '0;
        repeat (40) step();
    endtask

    initial begin
        reset_n      = 1'b0;
        s_tick       = 1'b0;
        tx_done_tick = 1'b0;
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        b_valid      = '0;
        b_data       = '0;
        b_last       = '0;
        b_done       = 1'b0;
        for (int i = 0; i < N; i++) took[i] = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_packet_lock();
        test_stall();
        test_reset_mid_send();
        test_gap_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among N_REQ byte-stream requesters.
- Round-robin arbitration at packet granularity: a granted requester keeps the transmitter until its last byte completes.
- Sequences the transmitter with a tx_start / tx_done_tick handshake.
- Enforces an inter-packet idle gap and a mid-packet stall timeout, both counted in the same 16x oversampling s_tick used by the receiver.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- D_BITS, 8: data bits per byte.
- GAP_TICKS, 16: s_ticks of enforced idle after each packet; 0 means no gap.
- STALL_TICKS, 255: s_ticks a granted requester may withhold its next byte before forced release (at least 1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_tick  in  1  baud oversampling tick, one clk wide.
- req_valid  in  N_REQ  byte available from requester i.
- req_data  in  N_REQ*D_BITS  byte of requester i at [i*D_BITS +: D_BITS].
- req_last  in  N_REQ  current byte of requester i ends its packet.
- req_ready  out  N_REQ  byte accepted from requester i when req_valid[i] is also high.
- grant  out  N_REQ  one-hot current owner; all zero when no owner.
- tx_start  out  1  one-clk pulse to start transmitter on tx_din.
- tx_din  out  D_BITS  byte for transmitter.
- tx_done_tick  in  1  transmitter finished byte (one clk).
- busy  out  1  high whenever state is not IDLE.
- abort_tick  out  1  one-clk pulse on stall-timeout release.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; counters 0.
- Reset mid-operation returns to IDLE immediately. The transmitter is not aborted; a tx_done_tick arriving later is ignored.
- States: IDLE, LOAD, SEND, GAP.
- IDLE:
  - If any req_valid is high, pick the first index i at or after ptr (mod N_REQ) with req_valid[i] high.
  - Next cycle: grant = one-hot(i), ptr = (i+1) mod N_REQ, state LOAD.
  - Arbitration costs exactly 1 clk.
- LOAD:
  - req_ready[g] = 1 for the granted index only (Moore, from state). All other req_ready are 0 in every state.
  - A transfer is req_valid[g] and req_ready[g] high in the same cycle. On it, register tx_din = req_data[g] and last_r = req_last[g]. Next cycle tx_start = 1 for exactly one clk; state SEND.
  - Stall counter clears on LOAD entry and increments per s_tick. If it reaches STALL_TICKS before a transfer: abort_tick = 1 for one clk, grant cleared, state GAP.
  - If a transfer and the final stall tick occur in the same cycle, the transfer wins.
- SEND:
  - req_ready all 0; tx_din held stable.
  - On tx_done_tick: if last_r, clear grant and go to GAP; otherwise go to LOAD.
  - Other requesters' req_valid never preempt the owner.
- GAP:
  - Counter clears on entry and increments per s_tick. Go to IDLE when it reaches GAP_TICKS.
  - If GAP_TICKS = 0, go to IDLE on the next clk.
  - grant is all zero throughout.
- tx_done_tick outside SEND is ignored. s_tick outside LOAD/GAP is ignored.
- Counter widths: $clog2(max+1) of the respective parameter. Counters saturate and never wrap.
- tx_din retains its last value when idle.

Test Plan:
- Single packet, GAP_TICKS=16: requester 0 sends 0xA5, 0x3C, 0x81 (last on 0x81), transmitter model returns tx_done_tick 160 clk after each tx_start.
  -> Exactly three tx_start pulses carrying those bytes in order.
  -> grant = 0001 until the third tx_done_tick.
  -> busy falls 16 s_ticks later.
- Simultaneous requests from 0 and 2, one-byte packets each, repeated twice.
  -> Grant order 0, 2, 0, 2.
  -> Never two one-hot bits high; no tx_start issued in GAP.
- Packet lock: requester 1 owns a 4-byte packet while requester 3 holds req_valid high throughout.
  -> grant stays 0010 until requester 1's last tx_done_tick.
  -> req_ready[3] stays 0 until then; requester 3 is granted after the gap.
- Stall: granted requester 2 sends one non-last byte then drops valid, STALL_TICKS=4.
  -> After the 4th s_tick in LOAD: abort_tick pulses once and grant clears.
  -> No further tx_start; requester 3 is served next.
- Reset mid-SEND: assert reset_n low during SEND.
  -> All outputs 0 asynchronously; ptr = 0.
  -> A subsequent stray tx_done_tick produces no tx_start.
  -> With requests pending from 1 and 3, requester 1 is granted first after release.
- GAP_TICKS=0 with back-to-back requests.
  -> IDLE is reached 1 clk after the final tx_done_tick.
  -> The next grant follows 1 clk later.
